// File: rtl/multi_shift_pkg.sv
// multi_shift_pkg: shift mode and FSM state encodings shared by the shift register.
package multi_shift_pkg;
   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_SLL  = 3'b001,
      OP_SRL  = 3'b010,
      OP_SRA  = 3'b011,
      OP_ROL  = 3'b100,
      OP_ROR  = 3'b101
   } shift_op_t;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shift_state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-position shifter for all shift modes.
module shift_step
   import multi_shift_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] word,
   input  shift_op_t        op,
   input  logic             serial_in,
   output logic [WIDTH-1:0] next_word,
   output logic             out_bit
);
   always_comb begin
      next_word = word;
      out_bit   = 1'b0;
      case (op)
         OP_SLL: begin
            next_word = {word[WIDTH-2:0], serial_in};
            out_bit   = word[WIDTH-1];
         end
         OP_SRL: begin
            next_word = {serial_in, word[WIDTH-1:1]};
            out_bit   = word[0];
         end
         OP_SRA: begin
            next_word = {word[WIDTH-1], word[WIDTH-1:1]};
            out_bit   = word[0];
         end
         OP_ROL: begin
            next_word = {word[WIDTH-2:0], word[WIDTH-1]};
            out_bit   = word[WIDTH-1];
         end
         OP_ROR: begin
            next_word = {word[0], word[WIDTH-1:1]};
            out_bit   = word[0];
         end
         default: begin
            next_word = word;
            out_bit   = 1'b0;
         end
      endcase
   end
endmodule

// File: rtl/multi_shift_register.sv
// multi_shift_register: loadable register with bit-serial multi-position shift
// under a start/busy/done handshake.
module multi_shift_register
   import multi_shift_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int AMT_WIDTH = $clog2(WIDTH) + 1
) (
   input  logic                 clock,
   input  logic                 reg_reset_n,
   input  logic [WIDTH-1:0]     reg_in,
   input  logic                 reg_wr,
   input  logic                 start,
   input  logic [2:0]           op,
   input  logic [AMT_WIDTH-1:0] amount,
   input  logic                 serial_in,
   output logic [WIDTH-1:0]     reg_out,
   output logic                 serial_out,
   output logic                 busy,
   output logic                 done
);
   shift_state_t         state;
   shift_op_t            op_q;
   logic [AMT_WIDTH-1:0] count;
   logic [WIDTH-1:0]     next_word;
   logic                 out_bit;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .word      (reg_out),
      .op        (op_q),
      .serial_in (serial_in),
      .next_word (next_word),
      .out_bit   (out_bit)
   );

   // busy mirrors state != IDLE but is kept as its own flop so every output is registered
   always_ff @(posedge clock or negedge reg_reset_n) begin
      if (!reg_reset_n) begin
         state      <= IDLE;
         op_q       <= OP_HOLD;
         count      <= '0;
         reg_out    <= '0;
         serial_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (reg_wr) begin
                  reg_out    <= reg_in;
                  serial_out <= 1'b0;
               end else if (start) begin
                  op_q  <= shift_op_t'(op);
                  count <= amount;
                  busy  <= 1'b1;
                  state <= (amount == '0) ? DONE : SHIFT;
                  done  <= (amount == '0);
               end
            end
            SHIFT: begin
               if (reg_wr) begin
                  reg_out    <= reg_in;
                  serial_out <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  reg_out    <= next_word;
                  serial_out <= out_bit;
                  count      <= count - 1'b1;
                  state      <= (count == AMT_WIDTH'(1)) ? DONE : SHIFT;
                  done       <= (count == AMT_WIDTH'(1));
               end
            end
            DONE: begin
               if (reg_wr) begin
                  reg_out    <= reg_in;
                  serial_out <= 1'b0;
               end
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_multi_shift_register.sv
// tb_multi_shift_register: directed vectors with hand-computed expectations.
module tb_multi_shift_register;
   import multi_shift_pkg::*;
   localparam int W  = 16;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reg_reset_n = 1'b0;
   logic [W-1:0]  reg_in = '0;
   logic          reg_wr = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op = 3'b000;
   logic [AW-1:0] amount = '0;
   logic          serial_in = 1'b0;
   logic [W-1:0]  reg_out;
   logic          serial_out;
   logic          busy;
   logic          done;

   int vectors = 0;
   int errs = 0;
   int cyc;
   logic saw_done;

   multi_shift_register #(.WIDTH(W), .AMT_WIDTH(AW)) dut (
      .clock       (clock),
      .reg_reset_n (reg_reset_n),
      .reg_in      (reg_in),
      .reg_wr      (reg_wr),
      .start       (start),
      .op          (op),
      .amount      (amount),
      .serial_in   (serial_in),
      .reg_out     (reg_out),
      .serial_out  (serial_out),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [W-1:0] v);
      reg_wr = 1'b1;
      reg_in = v;
      tick();
      reg_wr = 1'b0;
   endtask

   task automatic launch(input logic [2:0] o, input int amt);
      start  = 1'b1;
      op     = o;
      amount = AW'(amt);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int c);
      c = 0;
      while (!done && c < max) begin
         tick();
         c++;
      end
   endtask

   initial begin
      #3;
      chk("reset_reg_out", 32'(reg_out), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_serial_out", 32'(serial_out), 32'h0);
      tick();
      reg_reset_n = 1'b1;
      tick();

      // SLL with fill, cycle by cycle
      load(16'h8001);
      serial_in = 1'b1;
      launch(OP_SLL, 3);
      chk("sll_busy_e0", 32'(busy), 32'h1);
      chk("sll_done_e0", 32'(done), 32'h0);
      tick();
      chk("sll_e1", 32'(reg_out), 32'h0003);
      chk("sll_so_e1", 32'(serial_out), 32'h1);
      chk("sll_done_e1", 32'(done), 32'h0);
      tick();
      chk("sll_e2", 32'(reg_out), 32'h0007);
      chk("sll_so_e2", 32'(serial_out), 32'h0);
      tick();
      chk("sll_e3", 32'(reg_out), 32'h000F);
      chk("sll_so_e3", 32'(serial_out), 32'h0);
      chk("sll_done_e3", 32'(done), 32'h1);
      chk("sll_busy_e3", 32'(busy), 32'h1);
      tick();
      chk("sll_done_after", 32'(done), 32'h0);
      chk("sll_busy_after", 32'(busy), 32'h0);

      load(16'h8000);
      launch(OP_SRA, 4);
      wait_done(40, cyc);
      chk("sra_cycles", 32'(cyc), 32'd4);
      chk("sra_val", 32'(reg_out), 32'hF800);
      chk("sra_so", 32'(serial_out), 32'h0);
      tick();

      serial_in = 1'b0;
      load(16'h8000);
      launch(OP_SRL, 4);
      wait_done(40, cyc);
      chk("srl_cycles", 32'(cyc), 32'd4);
      chk("srl_val", 32'(reg_out), 32'h0800);
      tick();

      load(16'h1234);
      launch(OP_ROL, 4);
      wait_done(40, cyc);
      chk("rol_val", 32'(reg_out), 32'h2341);
      chk("rol_so", 32'(serial_out), 32'h1);
      tick();

      load(16'h0001);
      launch(OP_ROR, 16);
      wait_done(40, cyc);
      chk("ror16_cycles", 32'(cyc), 32'd16);
      chk("ror16_val", 32'(reg_out), 32'h0001);
      chk("ror16_so", 32'(serial_out), 32'h0);
      tick();

      // amount beyond WIDTH fills entirely with serial_in
      serial_in = 1'b1;
      load(16'h0000);
      launch(OP_SRL, 20);
      wait_done(60, cyc);
      chk("srl20_cycles", 32'(cyc), 32'd20);
      chk("srl20_val", 32'(reg_out), 32'hFFFF);
      tick();
      serial_in = 1'b0;

      load(16'h5A5A);
      launch(OP_SLL, 0);
      chk("zero_done", 32'(done), 32'h1);
      chk("zero_busy", 32'(busy), 32'h1);
      chk("zero_val", 32'(reg_out), 32'h5A5A);
      tick();
      chk("zero_done_after", 32'(done), 32'h0);
      chk("zero_busy_after", 32'(busy), 32'h0);

      launch(OP_HOLD, 2);
      wait_done(40, cyc);
      chk("hold_cycles", 32'(cyc), 32'd2);
      chk("hold_val", 32'(reg_out), 32'h5A5A);
      tick();

      // start held high during SHIFT and DONE must be ignored
      load(16'h00F0);
      launch(OP_SLL, 4);
      tick();
      start  = 1'b1;
      op     = OP_ROR;
      amount = AW'(1);
      wait_done(40, cyc);
      chk("busy_start_cycles", 32'(cyc), 32'd3);
      chk("busy_start_val", 32'(reg_out), 32'h0F00);
      tick();
      start = 1'b0;
      chk("done_start_busy", 32'(busy), 32'h0);
      tick();
      chk("done_start_idle", 32'(busy), 32'h0);
      chk("done_start_val", 32'(reg_out), 32'h0F00);

      load(16'h1111);
      launch(OP_SRL, 8);
      tick();
      tick();
      load(16'hABCD);
      chk("abort_val", 32'(reg_out), 32'hABCD);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_so", 32'(serial_out), 32'h0);
      saw_done = done;
      for (int i = 0; i < 10; i++) begin
         tick();
         saw_done = saw_done | done;
      end
      chk("abort_no_done", 32'(saw_done), 32'h0);
      chk("abort_hold_val", 32'(reg_out), 32'hABCD);

      reg_wr = 1'b1;
      reg_in = 16'h7777;
      start  = 1'b1;
      op     = OP_SLL;
      amount = AW'(3);
      tick();
      reg_wr = 1'b0;
      start  = 1'b0;
      chk("prio_val", 32'(reg_out), 32'h7777);
      chk("prio_busy", 32'(busy), 32'h0);
      tick();
      chk("prio_busy2", 32'(busy), 32'h0);
      chk("prio_val2", 32'(reg_out), 32'h7777);

      load(16'hFFFF);
      launch(OP_SLL, 5);
      tick();
      chk("pre_rst_so", 32'(serial_out), 32'h1);
      #2;
      reg_reset_n = 1'b0;
      #1;
      chk("rst_mid_val", 32'(reg_out), 32'h0);
      chk("rst_mid_busy", 32'(busy), 32'h0);
      chk("rst_mid_done", 32'(done), 32'h0);
      chk("rst_mid_so", 32'(serial_out), 32'h0);
      tick();
      reg_reset_n = 1'b1;
      tick();
      chk("post_rst_busy", 32'(busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
